// File: rtl/mill_frame_parse.sv
// Miller-decoded bit stream to ISO14443A bytes: odd-parity check, CRC_A residue, frame classification.
// Byte strobe and frame status are registered, one cycle after the accepting bit/EOF; no backpressure.
module mill_frame_parse #(
   parameter int          CNT_W    = 6,
   parameter logic [15:0] CRC_INIT = 16'h6363
) (
   input  logic             clk,
   input  logic             in_PoR,
   input  logic             in_enable,
   input  logic             in_bit_valid,
   input  logic             in_bit,
   input  logic             in_eof,
   output logic [7:0]       out_byte,
   output logic             out_byte_valid,
   output logic             out_parity_err,
   output logic [CNT_W-1:0] out_byte_count,
   output logic             out_frame_done,
   output logic             out_short_frame,
   output logic             out_crc_ok,
   output logic             out_frame_err
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_DONE} state_t;

   state_t           r_state;
   logic [7:0]       r_sr;
   logic [2:0]       r_bitcnt;
   logic [15:0]      r_crc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_perr;
   logic [7:0]       r_byte;
   logic             r_byte_vld;
   logic             r_done;
   logic             r_short;
   logic             r_crc_ok;
   logic             r_ferr;

   state_t           w_state_n;
   logic [7:0]       w_sr_n;
   logic [2:0]       w_bitcnt_n;
   logic [15:0]      w_crc_n;
   logic [CNT_W-1:0] w_cnt_n;
   logic             w_perr_n;
   logic             w_byte_acc;
   logic             w_in_frame;
   logic             w_abort;
   logic             w_eof;
   logic             w_short;
   logic             w_ok;
   logic             w_crc_ok;

   // Reflected CRC_A, one bit per step
   function automatic logic [15:0] f_crc(input logic [15:0] c, input logic b);
      logic        fb;
      logic [15:0] n;
      fb = c[0] ^ b;
      n  = c >> 1;
      if (fb) n = n ^ 16'h8408;
      return n;
   endfunction

   // Next-state view including this cycle's bit, so an EOF in the same cycle classifies it
   always_comb begin
      w_state_n  = r_state;
      w_sr_n     = r_sr;
      w_bitcnt_n = r_bitcnt;
      w_crc_n    = r_crc;
      w_cnt_n    = r_cnt;
      w_perr_n   = r_perr;
      w_byte_acc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_enable && in_bit_valid) begin
               w_state_n  = S_DATA;
               w_sr_n     = {in_bit, 7'h00};
               w_bitcnt_n = 3'd1;
               w_crc_n    = f_crc(CRC_INIT, in_bit);
               w_cnt_n    = '0;
               w_perr_n   = 1'b0;
            end
         end
         S_DATA: begin
            if (in_bit_valid) begin
               w_sr_n     = {in_bit, r_sr[7:1]};
               w_crc_n    = f_crc(r_crc, in_bit);
               w_bitcnt_n = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) w_state_n = S_PARITY;
            end
         end
         S_PARITY: begin
            if (in_bit_valid) begin
               w_byte_acc = 1'b1;
               w_state_n  = S_DATA;
               if (~^{r_sr, in_bit}) w_perr_n = 1'b1;
               if (r_cnt != {CNT_W{1'b1}}) w_cnt_n = r_cnt + 1'b1;
            end
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase

      w_in_frame = (r_state == S_DATA) || (r_state == S_PARITY);
      w_abort    = w_in_frame && !in_enable;
      w_eof      = w_in_frame && in_enable && in_eof;
      w_short    = (w_state_n == S_DATA) && (w_bitcnt_n == 3'd7) && (w_cnt_n == '0);
      w_ok       = (w_state_n == S_DATA) && (w_bitcnt_n == 3'd0);
      w_crc_ok   = (w_crc_n == 16'h0000) && (w_cnt_n >= CNT_W'(3));
   end

   always_ff @(posedge clk or negedge in_PoR) begin
      if (!in_PoR) begin
         r_state    <= S_IDLE;
         r_sr       <= 8'h00;
         r_bitcnt   <= 3'd0;
         r_crc      <= CRC_INIT;
         r_cnt      <= '0;
         r_perr     <= 1'b0;
         r_byte     <= 8'h00;
         r_byte_vld <= 1'b0;
         r_done     <= 1'b0;
         r_short    <= 1'b0;
         r_crc_ok   <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_byte_vld <= 1'b0;
         r_done     <= 1'b0;
         if (w_abort) begin
            // Abandon the frame silently; last frame's flags stay visible
            r_state <= S_IDLE;
         end else begin
            r_state  <= w_state_n;
            r_sr     <= w_sr_n;
            r_bitcnt <= w_bitcnt_n;
            r_crc    <= w_crc_n;
            r_cnt    <= w_cnt_n;
            r_perr   <= w_perr_n;
            if (w_byte_acc) begin
               r_byte     <= r_sr;
               r_byte_vld <= 1'b1;
            end
            if (w_eof) begin
               r_state  <= S_DONE;
               r_done   <= 1'b1;
               r_short  <= w_short;
               r_crc_ok <= w_crc_ok;
               r_ferr   <= !(w_short || w_ok);
               if (w_short) r_byte <= {1'b0, w_sr_n[7:1]};
            end
         end
      end
   end

   assign out_byte        = r_byte;
   assign out_byte_valid  = r_byte_vld;
   assign out_parity_err  = r_perr;
   assign out_byte_count  = r_cnt;
   assign out_frame_done  = r_done;
   assign out_short_frame = r_short;
   assign out_crc_ok      = r_crc_ok;
   assign out_frame_err   = r_ferr;

endmodule
